register_dispatch: RTL

Delivery side of the register datapath. Accepts one n-bit word per transfer, tagged with a 2-bit destination select, and delivers it over a valid/ready handshake to exactly one of four consumer channels. A 2-entry FIFO decouples the producer from the consumers, so back-to-back transfers sustain one word per cycle. This is the counterpart of the 4-way select-and-load register: that block gathers one of four sources into a register, this block scatters a register value to one of four sinks.

---
 rtl/register_dispatch_if.sv | 35 +++
 rtl/register_dispatch.sv | 96 +++++++++
 2 files changed

// File: rtl/register_dispatch_if.sv
// rtl/register_dispatch_if.sv - producer/consumer bus of the register dispatcher
// in_broadcast exists only when REGISTER_DISPATCH_BROADCAST_EN is defined.
interface register_dispatch_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [1:0]   in_select;
`ifdef REGISTER_DISPATCH_BROADCAST_EN
  logic         in_broadcast;
`endif
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   level;

  modport slave (
    input  in_valid, in_data, in_select,
`ifdef REGISTER_DISPATCH_BROADCAST_EN
    input  in_broadcast,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data, level
  );

  modport master (
    output in_valid, in_data, in_select,
`ifdef REGISTER_DISPATCH_BROADCAST_EN
    output in_broadcast,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/register_dispatch.sv
// rtl/register_dispatch.sv - 2-entry FIFO scattering words to one of four consumer channels
// REGISTER_DISPATCH_BROADCAST_EN adds broadcast entries delivered to all four channels.
module register_dispatch #(
  parameter int unsigned N = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  register_dispatch_if.slave   bus
);

  logic [N-1:0] data_q [2];
  logic [1:0]   sel_q  [2];
  logic         wr_q, rd_q;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q;
  logic [N-1:0] last_q;
  logic [3:0]   out_valid;
  logic         push, pop;
`ifdef REGISTER_DISPATCH_BROADCAST_EN
  logic         bc_q [2];
  logic [3:0]   done_q, done_d;
`endif

  always_comb begin
    out_valid = '0;
    pop       = 1'b0;
`ifdef REGISTER_DISPATCH_BROADCAST_EN
    done_d    = done_q;
`endif
    if (count_q != 2'd0) begin
`ifdef REGISTER_DISPATCH_BROADCAST_EN
      // A broadcast head pops once earlier and current acceptances cover all channels.
      if (bc_q[rd_q]) begin
        out_valid = ~done_q;
        pop       = &(done_q | (out_valid & bus.out_ready));
        done_d    = pop ? 4'b0000 : (done_q | (out_valid & bus.out_ready));
      end else
`endif
      begin
        out_valid = 4'b0001 << sel_q[rd_q];
        pop       = |(out_valid & bus.out_ready);
      end
    end
  end

  // in_ready is registered, so out_ready never reaches it combinationally.
  assign push    = bus.in_valid && in_ready_q;
  assign count_d = count_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= '0;
`ifdef REGISTER_DISPATCH_BROADCAST_EN
        bc_q[i]   <= 1'b0;
`endif
      end
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      last_q     <= '0;
`ifdef REGISTER_DISPATCH_BROADCAST_EN
      done_q     <= 4'b0000;
`endif
    end else begin
      if (push) begin
        data_q[wr_q] <= bus.in_data;
        sel_q[wr_q]  <= bus.in_select;
`ifdef REGISTER_DISPATCH_BROADCAST_EN
        bc_q[wr_q]   <= bus.in_broadcast;
`endif
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      // Tracks the head so an emptied FIFO keeps showing the last delivered word.
      if (count_q != 2'd0) begin
        last_q <= data_q[rd_q];
      end
`ifdef REGISTER_DISPATCH_BROADCAST_EN
      done_q <= done_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = (count_q != 2'd0) ? data_q[rd_q] : last_q;
  assign bus.level     = count_q;

endmodule
